// File: rtl/dequant_reconstruct_if.sv
// dequant_reconstruct_if: macroblock operands, reconstructed pixels and start/busy/done handshake.
interface dequant_reconstruct_if;
    logic          start;
    logic [2047:0] YPred;
    logic [255:0]  Y_dc_levels;
    logic [4095:0] Y_ac_levels;
    logic [255:0]  q1;
    logic [255:0]  q2;
    logic [2047:0] Yout;
    logic          busy;
    logic          done;
    modport master (output start, YPred, Y_dc_levels, Y_ac_levels, q1, q2, input Yout, busy, done);
    modport slave  (input start, YPred, Y_dc_levels, Y_ac_levels, q1, q2, output Yout, busy, done);
endinterface

// File: rtl/dequant_reconstruct.sv
// dequant_reconstruct: VP8 intra-16 luma reconstruction (dequant, inverse WHT, per-block IDCT + prediction).
// The 16 sub-blocks share one IDCT datapath, two cycles per block.
module dequant_reconstruct #(
    parameter int BLOCK_SIZE = 16
) (
    input logic clk,
    input logic rst_n,
    dequant_reconstruct_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_DQ, S_WHT_V, S_WHT_H, S_BLK_V, S_BLK_H, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_blk;
    logic signed [31:0]  r_dc [16], r_t [16], r_wdc [16];
    logic signed [31:0]  w_dc [16], w_t [16], w_wdc [16];
    logic signed [47:0]  r_u [16], w_u [16], w_c [16], w_r [4];
    logic signed [47:0]  w_pix;
    logic [2047:0]       r_yout, w_yout;
    int                  w_idx;

    function automatic logic signed [47:0] m1(input logic signed [47:0] v);
        logic signed [63:0] p;
        p = 64'(v) * 64'sd20091;
        return 48'(p >>> 16) + v;
    endfunction

    function automatic logic signed [47:0] m2(input logic signed [47:0] v);
        logic signed [63:0] p;
        p = 64'(v) * 64'sd35468;
        return 48'(p >>> 16);
    endfunction

    function automatic void bfly(input logic signed [47:0] i0, i1, i2, i3,
                                 output logic signed [47:0] o0, o1, o2, o3);
        logic signed [47:0] a, b, c, d;
        a = i0 + i2;
        b = i0 - i2;
        c = m2(i1) - m1(i3);
        d = m1(i1) + m2(i3);
        o0 = a + d;
        o1 = b + c;
        o2 = b - c;
        o3 = a - d;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_blk   <= '0;
            r_yout  <= '0;
        end else begin
            r_state <= w_next;
            r_blk   <= (r_state == S_DQ) ? 4'd0 : (r_state == S_BLK_H) ? r_blk + 4'd1 : r_blk;
            r_yout  <= (r_state == S_BLK_H) ? w_yout : r_yout;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.start ? S_DQ : S_IDLE;
            S_DQ:    w_next = S_WHT_V;
            S_WHT_V: w_next = S_WHT_H;
            S_WHT_H: w_next = S_BLK_V;
            S_BLK_V: w_next = S_BLK_H;
            S_BLK_H: w_next = (r_blk == 4'd15) ? S_DONE : S_BLK_V;
            S_DONE:  w_next = bus.start ? S_DQ : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Intermediate stages carry no reset: each is rewritten before it is consumed.
    always_ff @(posedge clk) begin
        if (r_state == S_DQ)    r_dc  <= w_dc;
        if (r_state == S_WHT_V) r_t   <= w_t;
        if (r_state == S_WHT_H) r_wdc <= w_wdc;
        if (r_state == S_BLK_V) r_u   <= w_u;
    end

    always_comb begin
        for (int k = 0; k < 16; k++)
            w_dc[k] = 32'($signed(bus.Y_dc_levels[16*k +: 16])) * 32'($signed({1'b0, bus.q2[16*k +: 16]}));
        for (int c = 0; c < 4; c++) begin
            w_t[c]    = (r_dc[c] + r_dc[12+c]) + (r_dc[4+c] + r_dc[8+c]);
            w_t[8+c]  = (r_dc[c] + r_dc[12+c]) - (r_dc[4+c] + r_dc[8+c]);
            w_t[4+c]  = (r_dc[c] - r_dc[12+c]) + (r_dc[4+c] - r_dc[8+c]);
            w_t[12+c] = (r_dc[c] - r_dc[12+c]) - (r_dc[4+c] - r_dc[8+c]);
        end
        for (int r = 0; r < 4; r++) begin
            w_wdc[4*r]   = ((r_t[4*r] + 32'sd3 + r_t[4*r+3]) + (r_t[4*r+1] + r_t[4*r+2])) >>> 3;
            w_wdc[4*r+1] = ((r_t[4*r] + 32'sd3 - r_t[4*r+3]) + (r_t[4*r+1] - r_t[4*r+2])) >>> 3;
            w_wdc[4*r+2] = ((r_t[4*r] + 32'sd3 + r_t[4*r+3]) - (r_t[4*r+1] + r_t[4*r+2])) >>> 3;
            w_wdc[4*r+3] = ((r_t[4*r] + 32'sd3 - r_t[4*r+3]) - (r_t[4*r+1] - r_t[4*r+2])) >>> 3;
        end
    end

    // Coefficient 0 of every block comes from the WHT; the level in lane j=0 is never used.
    always_comb begin
        w_yout = r_yout;
        w_r    = '{default: '0};
        w_pix  = '0;
        w_idx  = 0;
        for (int j = 0; j < 16; j++)
            w_c[j] = (j == 0) ? 48'(r_wdc[r_blk])
                   : 48'($signed(bus.Y_ac_levels[256*int'(r_blk) + 16*j +: 16])) * 48'($signed({1'b0, bus.q1[16*j +: 16]}));
        for (int n = 0; n < 4; n++)
            bfly(w_c[n], w_c[4+n], w_c[8+n], w_c[12+n], w_u[4*n], w_u[4*n+1], w_u[4*n+2], w_u[4*n+3]);
        for (int m = 0; m < 4; m++) begin
            bfly(r_u[m] + 48'sd4, r_u[4+m], r_u[8+m], r_u[12+m], w_r[0], w_r[1], w_r[2], w_r[3]);
            for (int x = 0; x < 4; x++) begin
                w_idx = 8 * (BLOCK_SIZE * (4*int'(r_blk[3:2]) + m) + 4*int'(r_blk[1:0]) + x);
                w_pix = $signed({40'd0, bus.YPred[w_idx +: 8]}) + (w_r[x] >>> 3);
                w_yout[w_idx +: 8] = (w_pix < 0) ? 8'd0 : (w_pix > 255) ? 8'd255 : w_pix[7:0];
            end
        end
    end

    assign bus.Yout = r_yout;
    assign bus.busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done = (r_state == S_DONE);
endmodule
